// File: rtl/test_verilator_timing_pkg.sv
// Shared constants and helpers for the timing delay-line pipe.
// A stage is laid out as {data, valid} with valid in the LSB; the top and the
// stage register each realise that layout with a WIDTH-dependent packed struct.
package test_verilator_timing_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 4;
   localparam int DEFAULT_CNT_W = 16;

   // Bit position of the valid flag inside a packed {data, valid} stage word.
   localparam int STAGE_VALID_BIT = 0;

   // Next occupancy on an advancing edge: one item may enter and one may leave,
   // result clamped to the physical stage count.
   function automatic int occ_update(input int occ, input logic add_item,
                                     input logic drop_item, input int depth);
      int n;
      n = occ;
      if (add_item) begin
         n = n + 32'sd1;
      end else begin
         n = n + 32'sd0;
      end
      if (drop_item) begin
         n = n - 32'sd1;
      end else begin
         n = n - 32'sd0;
      end
      if (n < 32'sd0) begin
         n = 32'sd0;
      end else if (n > depth) begin
         n = depth;
      end else begin
         n = n;
      end
      return n;
   endfunction

endpackage

// File: rtl/test_verilator_timing_pipe_if.sv
// Handshake/data bundle between the delay-line pipe and whatever drives it.
// master drives the input side and observes outputs; slave is the pipe itself.
interface test_verilator_timing_pipe_if
   import test_verilator_timing_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int CNT_W = DEFAULT_CNT_W
);

   localparam int OCC_W = $clog2(DEPTH + 1);

   logic             en;
   logic             flush;
   logic [WIDTH-1:0] d;
   logic             d_valid;
   logic [WIDTH-1:0] q;
   logic             q_valid;
   logic [OCC_W-1:0] occupancy;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] emit_cnt;

   modport master (
      output en, flush, d, d_valid,
      input  q, q_valid, occupancy, cycle_cnt, emit_cnt
   );

   modport slave (
      input  en, flush, d, d_valid,
      output q, q_valid, occupancy, cycle_cnt, emit_cnt
   );

endinterface

// File: rtl/test_verilator_timing_stage.sv
// One {data, valid} register of the delay line. Reset clears everything,
// flush clears only the valid flag (data may stay stale), en loads the
// upstream word, otherwise the stage holds.
module test_verilator_timing_stage
   import test_verilator_timing_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_en,
   input  logic           i_flush,
   input  logic [WIDTH:0] i_stage,
   output logic [WIDTH:0] o_stage
);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             valid;
   } stage_t;

   stage_t w_in;
   stage_t r_stage;

   assign w_in    = i_stage;
   assign o_stage = r_stage;

   // Stage register: reset > flush > advance > hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stage <= '0;
      end else if (i_flush) begin
         r_stage.valid <= 1'b0;
      end else if (i_en) begin
         r_stage <= w_in;
      end else begin
         r_stage <= r_stage;
      end
   end

endmodule

// File: rtl/test_verilator_timing_pipe.sv
// WIDTH-bit, DEPTH-stage delay line with per-stage valid, stall and flush,
// plus occupancy, free-running cycle counter and emitted-item counter.
// Every output comes straight from a register; nothing is combinational
// from the input side.
module test_verilator_timing_pipe
   import test_verilator_timing_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input logic                        clk,
   input logic                        rst,
   test_verilator_timing_pipe_if.slave bus
);

   localparam int OCC_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             valid;
   } stage_t;

   // w_stage[0] is the input word, w_stage[g+1] the output of stage g.
   stage_t           w_stage [0:DEPTH];
   stage_t           w_last;
   logic [OCC_W-1:0] r_occ;
   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_emit_cnt;

   assign w_stage[0] = {bus.d, bus.d_valid};
   assign w_last     = w_stage[DEPTH];

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      test_verilator_timing_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .i_en    (bus.en),
         .i_flush (bus.flush),
         .i_stage (w_stage[g]),
         .o_stage (w_stage[g+1])
      );
   end

   // Occupancy tracks the popcount of stage valid bits incrementally.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_occ <= '0;
      end else if (bus.flush) begin
         r_occ <= '0;
      end else if (bus.en) begin
         r_occ <= OCC_W'(occ_update(int'(r_occ), bus.d_valid, w_last.valid, DEPTH));
      end else begin
         r_occ <= r_occ;
      end
   end

   // Free-running edge counter since reset release; wraps naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cycle_cnt <= '0;
      end else begin
         r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      end
   end

   // Counts items leaving the last stage; a flush edge consumes nothing.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_emit_cnt <= '0;
      end else if (!bus.flush && bus.en && w_last.valid) begin
         r_emit_cnt <= r_emit_cnt + CNT_W'(1);
      end else begin
         r_emit_cnt <= r_emit_cnt;
      end
   end

   assign bus.q         = w_last.data;
   assign bus.q_valid   = w_last.valid;
   assign bus.occupancy = r_occ;
   assign bus.cycle_cnt = r_cycle_cnt;
   assign bus.emit_cnt  = r_emit_cnt;

endmodule

// File: tb/tb_test_verilator_timing_pipe.sv
// Directed bench for the timing delay-line pipe. Three instances share clk:
// main (8/4/16), wrap (8/4/4) for counter wrap and mid-stream reset, and
// small (1/1/16) for the single-stage configuration.
module tb_test_verilator_timing_pipe;

   logic clk;
   logic rst_m, rst_w, rst_s;
   int   checks;
   int   errors;
   int   m_cyc;

   test_verilator_timing_pipe_if #(.WIDTH(8), .DEPTH(4), .CNT_W(16)) bm ();
   test_verilator_timing_pipe_if #(.WIDTH(8), .DEPTH(4), .CNT_W(4))  bw ();
   test_verilator_timing_pipe_if #(.WIDTH(1), .DEPTH(1), .CNT_W(16)) bs ();

   test_verilator_timing_pipe #(.WIDTH(8), .DEPTH(4), .CNT_W(16)) u_main (
      .clk (clk), .rst (rst_m), .bus (bm)
   );
   test_verilator_timing_pipe #(.WIDTH(8), .DEPTH(4), .CNT_W(4)) u_wrap (
      .clk (clk), .rst (rst_w), .bus (bw)
   );
   test_verilator_timing_pipe #(.WIDTH(1), .DEPTH(1), .CNT_W(16)) u_small (
      .clk (clk), .rst (rst_s), .bus (bs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One posedge, then settle; also tracks expected main cycle_cnt.
   task automatic tick();
      @(posedge clk);
      if (rst_m) m_cyc = 0;
      else       m_cyc = m_cyc + 1;
      #1;
   endtask

   task automatic test_reset();
      rst_m = 1'b1; rst_w = 1'b1; rst_s = 1'b1;
      tick(); tick();
      checks++;
      if (bm.q_valid !== 1'b0 || bm.q !== 8'h00 || bm.occupancy !== 3'd0) begin
         errors++;
         $display("FAIL reset_out: q=%0h qv=%0b occ=%0d required 0/0/0", bm.q, bm.q_valid, bm.occupancy);
      end
      checks++;
      if (bm.cycle_cnt !== 16'd0 || bm.emit_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_cnt: cyc=%0d emit=%0d required 0/0", bm.cycle_cnt, bm.emit_cnt);
      end
      rst_m = 1'b0;
   endtask

   task automatic test_latency();
      bm.en = 1'b1; bm.d = 8'hA5; bm.d_valid = 1'b1;
      tick();
      bm.d = 8'h00; bm.d_valid = 1'b0;
      checks++;
      if (bm.occupancy !== 3'd1) begin
         errors++;
         $display("FAIL lat_occ1: occ=%0d required 1", bm.occupancy);
      end
      for (int k = 2; k <= 5; k++) begin
         if (k > 1 && k < 4) begin
            checks++;
            if (bm.q_valid !== 1'b0) begin
               errors++;
               $display("FAIL lat_early: edge %0d qv=%0b required 0", k - 1, bm.q_valid);
            end
         end
         tick();
      end
      // after 5 edges: item was visible after edge 4, gone after edge 5
      checks++;
      if (bm.q_valid !== 1'b0 || bm.emit_cnt !== 16'd1 || bm.occupancy !== 3'd0) begin
         errors++;
         $display("FAIL lat_after: qv=%0b emit=%0d occ=%0d required 0/1/0", bm.q_valid, bm.emit_cnt, bm.occupancy);
      end
      checks++;
      if (bm.cycle_cnt !== 16'(m_cyc) || m_cyc != 5) begin
         errors++;
         $display("FAIL lat_cycle: cyc=%0d required 5", bm.cycle_cnt);
      end
   endtask

   task automatic test_latency_edge4();
      // Repeat with an exact look at edge 4.
      bm.en = 1'b1; bm.d = 8'hA5; bm.d_valid = 1'b1;
      tick();
      bm.d = 8'h00; bm.d_valid = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (bm.q_valid !== 1'b1 || bm.q !== 8'hA5) begin
         errors++;
         $display("FAIL lat_edge4: q=%0h qv=%0b required a5/1", bm.q, bm.q_valid);
      end
      checks++;
      if (bm.emit_cnt !== 16'd1) begin
         errors++;
         $display("FAIL lat_emit_pre: emit=%0d required 1", bm.emit_cnt);
      end
      tick();
      checks++;
      if (bm.q_valid !== 1'b0 || bm.emit_cnt !== 16'd2) begin
         errors++;
         $display("FAIL lat_once: qv=%0b emit=%0d required 0/2", bm.q_valid, bm.emit_cnt);
      end
   endtask

   task automatic test_stall();
      logic [7:0] exp_q;
      bm.en = 1'b1; bm.d_valid = 1'b1;
      bm.d = 8'h01; tick();
      bm.d = 8'h02; tick();
      bm.d = 8'h03; tick();
      bm.en = 1'b0; bm.d = 8'h77;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (bm.q_valid !== 1'b0 || bm.occupancy !== 3'd3 || bm.emit_cnt !== 16'd2) begin
            errors++;
            $display("FAIL stall_hold: k=%0d qv=%0b occ=%0d emit=%0d required 0/3/2", k, bm.q_valid, bm.occupancy, bm.emit_cnt);
         end
      end
      checks++;
      if (bm.cycle_cnt !== 16'(m_cyc)) begin
         errors++;
         $display("FAIL stall_cycle: cyc=%0d required %0d", bm.cycle_cnt, m_cyc);
      end
      bm.en = 1'b1; bm.d_valid = 1'b0; bm.d = 8'h00;
      for (int k = 1; k <= 3; k++) begin
         tick();
         exp_q = 8'(k);
         checks++;
         if (bm.q_valid !== 1'b1 || bm.q !== exp_q || bm.occupancy !== 3'(4 - k)) begin
            errors++;
            $display("FAIL stall_order: q=%0h qv=%0b occ=%0d required %0h/1/%0d", bm.q, bm.q_valid, bm.occupancy, exp_q, 4 - k);
         end
      end
      tick();
      checks++;
      if (bm.q_valid !== 1'b0 || bm.occupancy !== 3'd0 || bm.emit_cnt !== 16'd5) begin
         errors++;
         $display("FAIL stall_drain: qv=%0b occ=%0d emit=%0d required 0/0/5", bm.q_valid, bm.occupancy, bm.emit_cnt);
      end
   endtask

   task automatic test_flush();
      bm.en = 1'b1; bm.d_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bm.d = 8'(8'h10 + k);
         tick();
      end
      checks++;
      if (bm.occupancy !== 3'd4 || bm.q_valid !== 1'b1 || bm.q !== 8'h10 || bm.emit_cnt !== 16'd5) begin
         errors++;
         $display("FAIL flush_fill: occ=%0d q=%0h qv=%0b emit=%0d required 4/10/1/5", bm.occupancy, bm.q, bm.q_valid, bm.emit_cnt);
      end
      bm.flush = 1'b1; bm.d = 8'hFF; bm.d_valid = 1'b1;
      tick();
      bm.flush = 1'b0; bm.d_valid = 1'b0; bm.d = 8'h00;
      checks++;
      if (bm.occupancy !== 3'd0 || bm.q_valid !== 1'b0 || bm.emit_cnt !== 16'd5) begin
         errors++;
         $display("FAIL flush_now: occ=%0d qv=%0b emit=%0d required 0/0/5", bm.occupancy, bm.q_valid, bm.emit_cnt);
      end
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++;
         if (bm.q_valid !== 1'b0 || bm.emit_cnt !== 16'd5) begin
            errors++;
            $display("FAIL flush_drop: k=%0d q=%0h qv=%0b emit=%0d required qv 0 emit 5", k, bm.q, bm.q_valid, bm.emit_cnt);
         end
      end
   endtask

   task automatic test_throughput();
      bm.en = 1'b1; bm.d_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bm.d = 8'(i);
         tick();
         checks++;
         if (bm.occupancy !== 3'((i + 1 < 4) ? i + 1 : 4)) begin
            errors++;
            $display("FAIL tput_occ: i=%0d occ=%0d required %0d", i, bm.occupancy, (i + 1 < 4) ? i + 1 : 4);
         end
         if (i >= 3) begin
            checks++;
            if (bm.q_valid !== 1'b1 || bm.q !== 8'(i - 3)) begin
               errors++;
               $display("FAIL tput_q: i=%0d q=%0h qv=%0b required %0h/1", i, bm.q, bm.q_valid, i - 3);
            end
         end else begin
            checks++;
            if (bm.q_valid !== 1'b0) begin
               errors++;
               $display("FAIL tput_fill: i=%0d qv=%0b required 0", i, bm.q_valid);
            end
         end
      end
      checks++;
      if (bm.emit_cnt !== 16'd21) begin
         errors++;
         $display("FAIL tput_emit: emit=%0d required 21 (5 + 16)", bm.emit_cnt);
      end
      bm.d_valid = 1'b0;
   endtask

   task automatic test_wrap_reset();
      rst_w = 1'b0; bw.en = 1'b0; bw.flush = 1'b0; bw.d = 8'h00; bw.d_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         checks++;
         if (bw.cycle_cnt !== 4'(k % 16)) begin
            errors++;
            $display("FAIL wrap_cycle: edge %0d cyc=%0d required %0d", k, bw.cycle_cnt, k % 16);
         end
      end
      bw.en = 1'b1; bw.d_valid = 1'b1;
      bw.d = 8'hC1; tick();
      bw.d = 8'hC2; tick();
      bw.d_valid = 1'b0; bw.d = 8'h00;
      checks++;
      if (bw.occupancy !== 3'd2 || bw.cycle_cnt !== 4'd6) begin
         errors++;
         $display("FAIL wrap_load: occ=%0d cyc=%0d required 2/6", bw.occupancy, bw.cycle_cnt);
      end
      rst_w = 1'b1;
      tick();
      rst_w = 1'b0;
      checks++;
      if (bw.q !== 8'h00 || bw.q_valid !== 1'b0 || bw.occupancy !== 3'd0 ||
          bw.cycle_cnt !== 4'd0 || bw.emit_cnt !== 4'd0) begin
         errors++;
         $display("FAIL wrap_rst: q=%0h qv=%0b occ=%0d cyc=%0d emit=%0d required all 0", bw.q, bw.q_valid, bw.occupancy, bw.cycle_cnt, bw.emit_cnt);
      end
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++;
         if (bw.q_valid !== 1'b0 || bw.emit_cnt !== 4'd0) begin
            errors++;
            $display("FAIL wrap_ghost: k=%0d q=%0h qv=%0b emit=%0d required qv 0 emit 0", k, bw.q, bw.q_valid, bw.emit_cnt);
         end
      end
   endtask

   task automatic test_depth1();
      logic last_d;
      rst_s = 1'b0; bs.en = 1'b1; bs.flush = 1'b0; bs.d_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         bs.d = 1'(k & 1);
         tick();
         checks++;
         if (bs.q !== 1'(k & 1) || bs.q_valid !== 1'b1 || bs.occupancy !== 1'b1) begin
            errors++;
            $display("FAIL d1_delay: k=%0d q=%0b qv=%0b occ=%0d required %0b/1/1", k, bs.q, bs.q_valid, bs.occupancy, k & 1);
         end
      end
      last_d = bs.d;
      bs.en = 1'b0; bs.d = ~last_d;
      tick();
      checks++;
      if (bs.q !== last_d) begin
         errors++;
         $display("FAIL d1_stall: q=%0b required %0b", bs.q, last_d);
      end
      checks++;
      if (bs.emit_cnt !== 16'd9) begin
         errors++;
         $display("FAIL d1_emit: emit=%0d required 9", bs.emit_cnt);
      end
   endtask

   initial begin
      checks = 0; errors = 0; m_cyc = 0;
      bm.en = 1'b0; bm.flush = 1'b0; bm.d = 8'h00; bm.d_valid = 1'b0;
      bw.en = 1'b0; bw.flush = 1'b0; bw.d = 8'h00; bw.d_valid = 1'b0;
      bs.en = 1'b0; bs.flush = 1'b0; bs.d = 1'b0; bs.d_valid = 1'b0;
      rst_m = 1'b1; rst_w = 1'b1; rst_s = 1'b1;
      test_reset();
      test_latency();
      test_latency_edge4();
      test_stall();
      test_flush();
      test_throughput();
      test_wrap_reset();
      test_depth1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
